// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with registered results, shift-add MULTU and optional
// restoring DIVU (compiled only when ALU_SEQ_DIV_EN is defined).
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MULTU = 4'd11;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'd12;
`endif

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
`ifdef ALU_SEQ_DIV_EN
    , S_DIV = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand (MULTU) or divisor (DIVU)
  logic [WIDTH-1:0] acc_q, acc_d;     // product high half or partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;       // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [SHW-1:0]   sh_amt;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_sh;
  logic             cnt_last;

  assign sh_amt   = b[SHW-1:0];
  assign cnt_last = (cnt_q == CNT_LAST);

  // Single-cycle datapath; unused codes (and DIVU when the divider is absent) give 0.
  always_comb begin
    simple_res = '0;
    case (op)
      OP_ADD:  simple_res = a + b;
      OP_SUB:  simple_res = a - b;
      OP_AND:  simple_res = a & b;
      OP_OR:   simple_res = a | b;
      OP_XOR:  simple_res = a ^ b;
      OP_NOR:  simple_res = ~(a | b);
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  simple_res = a << sh_amt;
      OP_SRL:  simple_res = a >> sh_amt;
      OP_SRA:  simple_res = $signed(a) >>> sh_amt;
      default: simple_res = '0;
    endcase
  end

  // Shift-add step: conditionally add the multiplicand, then shift {carry,acc,sh} right.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc = mul_sum[WIDTH:1];
    mul_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
  end

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] div_acc;
  logic [WIDTH-1:0] div_sh;

  // Restoring step; a zero divisor always "fits", yielding all-ones quotient and rem = a.
  always_comb begin
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!div_diff[WIDTH]) begin
      div_acc = div_diff[WIDTH-1:0];
      div_sh  = {sh_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc = div_shift[WIDTH-1:0];
      div_sh  = {sh_q[WIDTH-2:0], 1'b0};
    end
  end
`endif

  // Handshake: start is accepted on a rising edge only in IDLE or DONE; while busy it
  // is ignored. done pulses for one cycle with y/hi/zero updated on that same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    y_d     = y_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (op == OP_MULTU) begin
            state_d = S_MUL;
            cnt_d   = '0;
            opnd_d  = a;
            acc_d   = '0;
            sh_d    = b;
`ifdef ALU_SEQ_DIV_EN
          end else if (op == OP_DIVU) begin
            state_d = S_DIV;
            cnt_d   = '0;
            opnd_d  = b;
            acc_d   = '0;
            sh_d    = a;
`endif
          end else begin
            state_d = S_DONE;
            y_d     = simple_res;
            hi_d    = '0;
            zero_d  = (simple_res == '0);
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        sh_d  = mul_sh;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          y_d     = mul_sh;
          hi_d    = mul_acc;
          zero_d  = (mul_sh == '0);
          done_d  = 1'b1;
        end
      end
`ifdef ALU_SEQ_DIV_EN
      S_DIV: begin
        acc_d = div_acc;
        sh_d  = div_sh;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          y_d     = div_sh;
          hi_d    = div_acc;
          zero_d  = (div_sh == '0);
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      y_q     <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign y           = y_q;
  assign hi          = hi_q;
  assign zero        = zero_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;
`ifdef ALU_SEQ_DIV_EN
  assign busy = (state_q == S_MUL) || (state_q == S_DIV);
`else
  assign busy = (state_q == S_MUL);
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: a 32-bit instance for the main sweep and
// an 8-bit instance for the narrow-width cases; DIVU expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
  localparam logic [3:0] NOR_ = 4'd5, SLT = 4'd6, SLTU = 4'd7, SLL = 4'd8, SRL = 4'd9;
  localparam logic [3:0] SRA = 4'd10, MULTU = 4'd11, DIVU = 4'd12, OP13 = 4'd13;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b, y, hi;
  logic        zero, busy, done;
  logic [1:0]  st;

  logic        start8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, y8, hi8;
  logic        zero8, busy8, done8;
  logic [1:0]  st8;

  alu_seq #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .y(y), .hi(hi), .zero(zero), .busy(busy), .done(done), .dbg_state_o(st)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .y(y8), .hi(hi8), .zero(zero8), .busy(busy8), .done(done8), .dbg_state_o(st8)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver: present one request for one edge, then scramble operands
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = z;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Runs an op to completion; lat = edges after the accepting edge until done shows.
  // If inject_k matches a cycle, an ADD start is pulsed there (must be ignored if busy).
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z,
                        input int inject_k, output int lat, output int bc);
    int k;
    issue(o, x, z);
    k = 1; bc = 0;
    while (!done && k < 200) begin
      if (busy) bc++;
      if (k == inject_k) begin
        start = 1'b1; op = ADD; a = 32'd3; b = 32'd4;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    lat = k - 1;
  endtask

  logic [3:0]  sw_op[14];
  logic [31:0] sw_a[14], sw_b[14], sw_y[14];
  int lat, bc, done_seen, done_run;
  logic [31:0] e;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    #12;
    chk("rst_y", y, 0);
    chk("rst_hi", hi, 0);
    chk("rst_zero", zero, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", st, 0);
    @(negedge clk);
    reset = 1'b0;

    // Make y nonzero, then abort a MULTU with reset
    run_op(ADD, 32'd1, 32'd1, 0, lat, bc);
    chk("add1_y", y, 2);
    issue(MULTU, 32'd5, 32'd6);
    chk("mul_busy_k1", busy, 1);
    chk("mul_state_k1", st, 1);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_y", y, 0);
    chk("abort_hi", hi, 0);
    chk("abort_zero", zero, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);

    run_op(ADD, 32'd3, 32'd4, 0, lat, bc);
    chk("add_lat", lat, 0);
    chk("add_y", y, 7);
    chk("add_zero", zero, 0);
    chk("add_hi", hi, 0);
    chk("add_busy", bc, 0);
    @(negedge clk);
    chk("add_done_pulse", done, 0);
    chk("add_idle", st, 0);

    // Back-to-back single-cycle sweep
    sw_op[0]  = SUB;  sw_a[0]  = 32'd5;        sw_b[0]  = 32'd7;  sw_y[0]  = 32'hFFFFFFFE;
    sw_op[1]  = SLT;  sw_a[1]  = 32'hFFFFFFFF; sw_b[1]  = 32'd1;  sw_y[1]  = 32'd1;
    sw_op[2]  = SLTU; sw_a[2]  = 32'hFFFFFFFF; sw_b[2]  = 32'd1;  sw_y[2]  = 32'd0;
    sw_op[3]  = SRA;  sw_a[3]  = 32'h80000000; sw_b[3]  = 32'd4;  sw_y[3]  = 32'hF8000000;
    sw_op[4]  = SLL;  sw_a[4]  = 32'd1;        sw_b[4]  = 32'd31; sw_y[4]  = 32'h80000000;
    sw_op[5]  = AND_; sw_a[5]  = 32'h0000F0F0; sw_b[5]  = 32'h0000FF00; sw_y[5] = 32'h0000F000;
    sw_op[6]  = OR_;  sw_a[6]  = 32'h0000F0F0; sw_b[6]  = 32'h00000F0F; sw_y[6] = 32'h0000FFFF;
    sw_op[7]  = XOR_; sw_a[7]  = 32'h0000FFFF; sw_b[7]  = 32'h000000FF; sw_y[7] = 32'h0000FF00;
    sw_op[8]  = NOR_; sw_a[8]  = 32'd0;        sw_b[8]  = 32'd0;  sw_y[8]  = 32'hFFFFFFFF;
    sw_op[9]  = SRL;  sw_a[9]  = 32'h80000000; sw_b[9]  = 32'd4;  sw_y[9]  = 32'h08000000;
    sw_op[10] = SLL;  sw_a[10] = 32'd1;        sw_b[10] = 32'h21; sw_y[10] = 32'd2;
    sw_op[11] = ADD;  sw_a[11] = 32'hFFFFFFFF; sw_b[11] = 32'd1;  sw_y[11] = 32'd0;
    sw_op[12] = 4'd14; sw_a[12] = 32'd5;       sw_b[12] = 32'd5;  sw_y[12] = 32'd0;
    sw_op[13] = SUB;  sw_a[13] = 32'd9;        sw_b[13] = 32'd2;  sw_y[13] = 32'd7;
    for (int i = 0; i < 14; i++) exp_q.push_back(sw_y[i]);
    @(negedge clk);
    start = 1'b1; op = sw_op[0]; a = sw_a[0]; b = sw_b[0];
    done_run = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (done) done_run++;
      chk($sformatf("sweep%0d_y", i), y, e);
      chk($sformatf("sweep%0d_zero", i), zero, (e == 32'd0));
      chk($sformatf("sweep%0d_hi", i), hi, 0);
      chk($sformatf("sweep%0d_busy", i), busy, 0);
      if (i < 13) begin
        op = sw_op[i+1]; a = sw_a[i+1]; b = sw_b[i+1];
      end else begin
        start = 1'b0;
      end
    end
    chk("sweep_done_run", done_run, 14);
    @(negedge clk);
    chk("sweep_done_end", done, 0);

    // MULTU full-scale, with an ignored ADD request while busy
    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, lat, bc);
    chk("mul_lat", lat, 32);
    chk("mul_busy_cycles", bc, 32);
    chk("mul_done", done, 1);
    chk("mul_y", y, 32'h00000001);
    chk("mul_hi", hi, 32'hFFFFFFFE);
    chk("mul_zero", zero, 0);
    @(negedge clk);
    chk("mul_done_pulse", done, 0);
    chk("mul_hold_y", y, 32'h00000001);
    chk("mul_idle", st, 0);

    run_op(MULTU, 32'h00010000, 32'h00010000, 0, lat, bc);
    chk("mul2_y", y, 0);
    chk("mul2_hi", hi, 1);
    chk("mul2_zero", zero, 1);

`ifdef ALU_SEQ_DIV_EN
    run_op(DIVU, 32'd100, 32'd7, 0, lat, bc);
    chk("div_lat", lat, 32);
    chk("div_busy_cycles", bc, 32);
    chk("div_y", y, 14);
    chk("div_hi", hi, 2);
    chk("div_zero", zero, 0);
    run_op(DIVU, 32'd9, 32'd0, 0, lat, bc);
    chk("div0_lat", lat, 32);
    chk("div0_y", y, 32'hFFFFFFFF);
    chk("div0_hi", hi, 9);
`else
    run_op(DIVU, 32'd100, 32'd7, 0, lat, bc);
    chk("nodiv_lat", lat, 0);
    chk("nodiv_busy", bc, 0);
    chk("nodiv_y", y, 0);
    chk("nodiv_hi", hi, 0);
    chk("nodiv_zero", zero, 1);
`endif

    run_op(OP13, 32'd1, 32'd2, 0, lat, bc);
    run_op(SUB, 32'd10, 32'd3, 0, lat, bc);
    chk("sub_after_y", y, 7);
    chk("sub_after_hi", hi, 0);

    // 8-bit instance
    @(negedge clk);
    start8 = 1'b1; op8 = MULTU; a8 = 8'hFF; b8 = 8'h02;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h55; b8 = 8'hAA;
    lat = 0;
    while (!done8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("w8_mul_lat", lat, 8);
    chk("w8_mul_y", y8, 8'hFE);
    chk("w8_mul_hi", hi8, 8'h01);
    @(negedge clk);
    start8 = 1'b1; op8 = ADD; a8 = 8'h80; b8 = 8'h80;
    @(negedge clk);
    start8 = 1'b0;
    chk("w8_add_done", done8, 1);
    chk("w8_add_y", y8, 8'h00);
    chk("w8_add_zero", zero8, 1);
    chk("w8_add_hi", hi8, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
